// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: test-pattern source feeding Hdmi's 24-bit rgb input.
// It consumes the Hdmi raster position and offers four patterns: border,
// colour bars, checkerboard and bouncing box. The pattern is latched only at
// frame start, so switching never tears a frame. A frame counter is included.
// Optional build macro: HDMI_PATTERN_GRAY_EN adds a gray_en input and one
// extra output register stage that can replace the colour with luma.
module hdmi_pattern_gen #(
  parameter int BIT_WIDTH    = 10,
  parameter int BIT_HEIGHT   = 10,
  parameter int BOX_SIZE     = 32,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic [1:0]            pattern_sel,
`ifdef HDMI_PATTERN_GRAY_EN
  input  logic                  gray_en,
`endif
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [BIT_WIDTH-1:0]  screen_start_x,
  input  logic [BIT_HEIGHT-1:0] screen_start_y,
  input  logic [BIT_WIDTH-1:0]  frame_width,
  input  logic [BIT_HEIGHT-1:0] frame_height,
  input  logic [BIT_WIDTH-1:0]  screen_width,
  input  logic [BIT_HEIGHT-1:0] screen_height,
  output logic [23:0]           rgb,
  output logic [7:0]            frame_count
);

  localparam logic [BIT_WIDTH-1:0]  ONE_W = BIT_WIDTH'(1);
  localparam logic [BIT_HEIGHT-1:0] ONE_H = BIT_HEIGHT'(1);
  localparam logic [BIT_WIDTH-1:0]  BOX_W = BIT_WIDTH'(BOX_SIZE);
  localparam logic [BIT_HEIGHT-1:0] BOX_H = BIT_HEIGHT'(BOX_SIZE);

  typedef enum logic [1:0] {
    MODE_BORDER  = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOX     = 2'd3
  } mode_t;

  // Registered state
  mode_t                 mode_reg;
  logic [BIT_WIDTH-1:0]  bar_width_reg;
  logic [BIT_WIDTH-1:0]  bar_cnt_reg,  bar_cnt_next;
  logic [2:0]            bar_idx_reg,  bar_idx_next;
  logic [BIT_WIDTH-1:0]  box_x_reg,    box_x_next;
  logic [BIT_HEIGHT-1:0] box_y_reg,    box_y_next;
  logic                  dir_x_reg,    dir_x_next;   // 1 = moving towards max
  logic                  dir_y_reg,    dir_y_next;
  logic [23:0]           pix_next;

  // Raster decode
  logic                  frame_start;
  logic                  active;
  logic [BIT_WIDTH-1:0]  x;
  logic [BIT_HEIGHT-1:0] y;
  logic [BIT_WIDTH-1:0]  max_x;
  logic [BIT_HEIGHT-1:0] max_y;
  logic [BIT_WIDTH:0]    box_x_end;
  logic [BIT_HEIGHT:0]   box_y_end;
  logic                  in_box;

  assign frame_start = (cx == '0) && (cy == '0);
  assign active      = (cx >= screen_start_x) && (cy >= screen_start_y);
  // Offsets are only consumed while active, so they never wrap in use.
  assign x           = cx - screen_start_x;
  assign y           = cy - screen_start_y;
  assign max_x       = screen_width  - BOX_W;
  assign max_y       = screen_height - BOX_H;
  // One extra bit so a box near the right/bottom edge cannot overflow.
  assign box_x_end   = {1'b0, box_x_reg} + {1'b0, BOX_W};
  assign box_y_end   = {1'b0, box_y_reg} + {1'b0, BOX_H};
  assign in_box      = (x >= box_x_reg) && ({1'b0, x} < box_x_end) &&
                       (y >= box_y_reg) && ({1'b0, y} < box_y_end);

  // Bar palette: each channel is one inverted bit of the bar index.
  logic [23:0] bar_palette [8];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_palette
      localparam logic [2:0] IDX = 3'(gi);
      assign bar_palette[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
    end
  endgenerate

  // Box bounce: one step per axis on every frame start, in all modes.
  always_comb begin
    box_x_next = box_x_reg;
    box_y_next = box_y_reg;
    dir_x_next = dir_x_reg;
    dir_y_next = dir_y_reg;
    if (frame_start) begin
      if (dir_x_reg) begin
        if (box_x_reg == max_x) begin
          box_x_next = max_x - ONE_W;
          dir_x_next = 1'b0;
        end else begin
          box_x_next = box_x_reg + ONE_W;
        end
      end else begin
        if (box_x_reg == '0) begin
          box_x_next = ONE_W;
          dir_x_next = 1'b1;
        end else begin
          box_x_next = box_x_reg - ONE_W;
        end
      end
      if (dir_y_reg) begin
        if (box_y_reg == max_y) begin
          box_y_next = max_y - ONE_H;
          dir_y_next = 1'b0;
        end else begin
          box_y_next = box_y_reg + ONE_H;
        end
      end else begin
        if (box_y_reg == '0) begin
          box_y_next = ONE_H;
          dir_y_next = 1'b1;
        end else begin
          box_y_next = box_y_reg - ONE_H;
        end
      end
    end
  end

  // Bar tracking without a divider; the pixel uses the updated index so the
  // colour changes exactly on the first pixel of each new bar.
  always_comb begin
    bar_cnt_next = bar_cnt_reg;
    bar_idx_next = bar_idx_reg;
    if (cx == screen_start_x) begin
      bar_cnt_next = '0;
      bar_idx_next = '0;
    end else if (active) begin
      if (bar_cnt_reg == bar_width_reg - ONE_W) begin
        bar_cnt_next = '0;
        if (bar_idx_reg != 3'd7) begin
          bar_idx_next = bar_idx_reg + 3'd1;
        end
      end else begin
        bar_cnt_next = bar_cnt_reg + ONE_W;
      end
    end
  end

  // Pixel colour for the current raster position in the latched mode.
  always_comb begin
    pix_next = 24'h000000;
    case (mode_reg)
      MODE_BORDER: begin
        pix_next[23:16] = (cx == screen_start_x) ? 8'hFF : 8'h00;
        pix_next[15:8]  = (cy == screen_start_y) ? 8'hFF : 8'h00;
        pix_next[7:0]   = ((cx == frame_width - ONE_W) ||
                           (cy == frame_height - ONE_H)) ? 8'hFF : 8'h00;
      end
      MODE_BARS: begin
        if (active) pix_next = bar_palette[bar_idx_next];
      end
      MODE_CHECKER: begin
        if (active) pix_next = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? 24'hFFFFFF : 24'h000000;
      end
      MODE_BOX: begin
        if (active) pix_next = in_box ? 24'hFFFFFF : 24'h000040;
      end
      default: pix_next = 24'h000000;
    endcase
  end

  // Pattern state: mode, frame counter, bar geometry and box position.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg      <= MODE_BORDER;
      frame_count   <= 8'd0;
      bar_width_reg <= '0;
      bar_cnt_reg   <= '0;
      bar_idx_reg   <= '0;
      box_x_reg     <= '0;
      box_y_reg     <= '0;
      dir_x_reg     <= 1'b1;
      dir_y_reg     <= 1'b1;
    end else begin
      if (frame_start) begin
        mode_reg      <= mode_t'(pattern_sel);
        frame_count   <= frame_count + 8'd1;
        bar_width_reg <= screen_width >> 3;
      end
      bar_cnt_reg <= bar_cnt_next;
      bar_idx_reg <= bar_idx_next;
      box_x_reg   <= box_x_next;
      box_y_reg   <= box_y_next;
      dir_x_reg   <= dir_x_next;
      dir_y_reg   <= dir_y_next;
    end
  end

`ifdef HDMI_PATTERN_GRAY_EN
  logic [23:0] rgb_stage_reg;
  logic [9:0]  luma_sum;
  logic [7:0]  luma;

  assign luma_sum = {2'b00, rgb_stage_reg[23:16]} +
                    {1'b0, rgb_stage_reg[15:8], 1'b0} +
                    {2'b00, rgb_stage_reg[7:0]};
  assign luma     = luma_sum[9:2];

  // Two-stage output: colour stage, then optional luma replacement.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rgb_stage_reg <= 24'h000000;
      rgb           <= 24'h000000;
    end else begin
      rgb_stage_reg <= pix_next;
      rgb           <= gray_en ? {luma, luma, luma} : rgb_stage_reg;
    end
  end
`else
  // Single output register.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 24'h000000;
    end else begin
      rgb <= pix_next;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen with VIC1 raster geometry (800x525, 640x480 active).
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;

  logic        clk_pixel = 1'b0;
  logic        reset_n   = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [9:0]  cx = '0;
  logic [9:0]  cy = '0;
  logic [9:0]  screen_start_x = 10'd160;
  logic [9:0]  screen_start_y = 10'd45;
  logic [9:0]  frame_width    = 10'd800;
  logic [9:0]  frame_height   = 10'd525;
  logic [9:0]  screen_width   = 10'd640;
  logic [9:0]  screen_height  = 10'd480;
  logic [23:0] rgb;
  logic [7:0]  frame_count;

  int n_pass   = 0;
  int n_total  = 0;
  int fs_count = 0;
  int cur_mode = 0;

  typedef struct {
    logic [23:0] rgb;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          mode;
    int          x;
    int          y;
    logic [23:0] rgb;
    string       name;
  } vec_t;
  vec_t vecs[20];

  hdmi_pattern_gen #(
    .BIT_WIDTH(10), .BIT_HEIGHT(10), .BOX_SIZE(32), .CHECKER_LOG2(5)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .pattern_sel(pattern_sel),
    .cx(cx),
    .cy(cy),
    .screen_start_x(screen_start_x),
    .screen_start_y(screen_start_y),
    .frame_width(frame_width),
    .frame_height(frame_height),
    .screen_width(screen_width),
    .screen_height(screen_height),
    .rgb(rgb),
    .frame_count(frame_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one raster position for one clock; if chk, the expected colour is
  // queued now and popped once the registered output is visible.
  task automatic drive(input int x, input int y, input logic [1:0] sel,
                       input bit chk, input logic [23:0] exp, input string name);
    exp_t e;
    cx = 10'(x);
    cy = 10'(y);
    pattern_sel = sel;
    if (x == 0 && y == 0) fs_count++;
    if (chk) begin
      e.rgb = exp;
      e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk_pixel);
    #1;
    if (chk) begin
      if (exp_q.size() == 0) begin
        check({name, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check(e.name, {8'h00, rgb}, {8'h00, e.rgb});
      end
    end
  endtask

  // Reflected walk 0..m..0 with period 2m.
  function automatic int box_pos(input int n, input int m);
    int p;
    p = n % (2 * m);
    return (p <= m) ? p : (2 * m - p);
  endfunction

  task automatic check_box(input int n);
    int bx;
    int by;
    bx = box_pos(n, 608);
    by = box_pos(n, 448);
    drive(160 + bx, 45 + by, 2'd3, 1, 24'hFFFFFF, $sformatf("box n=%0d top-left", n));
    drive(160 + bx + 31, 45 + by + 31, 2'd3, 1, 24'hFFFFFF, $sformatf("box n=%0d bottom-right", n));
    drive(160 + bx + 32, 45 + by, 2'd3, 1, 24'h000040, $sformatf("box n=%0d right of box", n));
    drive(160 + bx, 45 + by + 32, 2'd3, 1, 24'h000040, $sformatf("box n=%0d below box", n));
    if (bx > 0) drive(159 + bx, 45 + by, 2'd3, 1, 24'h000040, $sformatf("box n=%0d left of box", n));
  endtask

  initial begin
    vecs[0]  = '{0, 160, 100, 24'hFF0000, "m0 left edge"};
    vecs[1]  = '{0, 300,  45, 24'h00FF00, "m0 top edge"};
    vecs[2]  = '{0, 799, 100, 24'h0000FF, "m0 right edge"};
    vecs[3]  = '{0, 300, 100, 24'h000000, "m0 interior"};
    vecs[4]  = '{0, 160,  45, 24'hFFFF00, "m0 top-left corner"};
    vecs[5]  = '{0, 300, 524, 24'h0000FF, "m0 bottom edge"};
    vecs[6]  = '{0, 100,  20, 24'h000000, "m0 blanking"};
    vecs[7]  = '{1, 160, 100, 24'hFFFFFF, "m1 bar0 start"};
    vecs[8]  = '{1, 239, 100, 24'hFFFFFF, "m1 bar0 last"};
    vecs[9]  = '{1, 240, 100, 24'hFFFF00, "m1 bar1 start"};
    vecs[10] = '{1, 400, 100, 24'h00FF00, "m1 bar3"};
    vecs[11] = '{1, 719, 100, 24'h0000FF, "m1 bar6 last"};
    vecs[12] = '{1, 799, 100, 24'h000000, "m1 bar7 last"};
    vecs[13] = '{1, 300,  20, 24'h000000, "m1 blanking"};
    vecs[14] = '{2, 160,  45, 24'h000000, "m2 origin"};
    vecs[15] = '{2, 191,  45, 24'h000000, "m2 x31"};
    vecs[16] = '{2, 192,  45, 24'hFFFFFF, "m2 x32"};
    vecs[17] = '{2, 192,  77, 24'h000000, "m2 x32 y32"};
    vecs[18] = '{2, 160,  77, 24'hFFFFFF, "m2 y32"};
    vecs[19] = '{2, 100, 100, 24'h000000, "m2 blanking"};

    // Power-up reset
    #2 reset_n = 1'b0;
    #1;
    check("reset rgb", {8'h00, rgb}, 32'h0);
    check("reset frame_count", {24'h0, frame_count}, 32'h0);
    repeat (2) @(posedge clk_pixel);
    #1;
    check("reset held rgb", {8'h00, rgb}, 32'h0);
    reset_n = 1'b1;

    // Mode must be border after reset even with another pattern requested.
    drive(160, 100, 2'd2, 1, 24'hFF0000, "post-reset mode 0");

    // Table of single-pixel vectors; a mode change costs one frame start and
    // bar pixels are reached by sweeping the row from the first active column.
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur_mode) begin
        drive(0, 0, 2'(vecs[i].mode), 1, 24'h000000, $sformatf("frame start to mode %0d", vecs[i].mode));
        cur_mode = vecs[i].mode;
      end
      if (vecs[i].mode == 1 && vecs[i].y >= 45 && vecs[i].x > 160) begin
        for (int k = 160; k < vecs[i].x; k++) drive(k, vecs[i].y, 2'd1, 0, 24'h0, "");
      end
      drive(vecs[i].x, vecs[i].y, 2'(vecs[i].mode), 1, vecs[i].rgb, vecs[i].name);
    end
    check("frame_count after table", {24'h0, frame_count}, 32'(fs_count & 255));

    // Mid-frame pattern request is ignored until the next frame start.
    drive(0, 0, 2'd0, 1, 24'h000000, "frame start to mode 0");
    check("frame_count before switch", {24'h0, frame_count}, 32'(fs_count & 255));
    drive(160, 200, 2'd1, 1, 24'hFF0000, "switch: border persists left");
    drive(300, 200, 2'd1, 1, 24'h000000, "switch: border interior");
    drive(799, 524, 2'd1, 1, 24'h0000FF, "switch: border at frame end");
    drive(0, 0, 2'd1, 1, 24'h000000, "switch: frame start");
    check("frame_count +1 per frame", {24'h0, frame_count}, 32'(fs_count & 255));
    for (int k = 160; k < 240; k++) drive(k, 100, 2'd1, (k == 160), 24'hFFFFFF, "switch: bars bar0");
    drive(240, 100, 2'd1, 1, 24'hFFFF00, "switch: bars bar1");

    // Asynchronous reset in the middle of a clock period, held for a while.
    #2 reset_n = 1'b0;
    #1;
    check("async reset rgb", {8'h00, rgb}, 32'h0);
    check("async reset frame_count", {24'h0, frame_count}, 32'h0);
    cx = '0;
    cy = '0;
    pattern_sel = 2'd3;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("reset held frame_count", {24'h0, frame_count}, 32'h0);
    check("reset held rgb 2", {8'h00, rgb}, 32'h0);
    reset_n = 1'b1;
    fs_count = 0;
    drive(160, 100, 2'd3, 1, 24'hFF0000, "after mid-frame reset mode 0");

    // Bouncing box
    repeat (3) drive(0, 0, 2'd3, 0, 24'h0, "");
    drive(163, 48, 2'd3, 1, 24'hFFFFFF, "box(3,3) inside");
    drive(162, 48, 2'd3, 1, 24'h000040, "box(3,3) left");
    check_box(3);
    repeat (606) drive(0, 0, 2'd3, 0, 24'h0, "");
    check_box(609);
    drive(0, 0, 2'd3, 1, 24'h000000, "box frame start 610");
    check_box(610);
    check("frame_count wrapped", {24'h0, frame_count}, 32'(fs_count & 255));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
